// File: rtl/alu_if.sv
// Handshake and operand/result bundle between the control unit and the sequential ALU.
interface alu_if #(
    parameter int unsigned WIDTH = 32
) ();
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             shiftsel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             negative;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, shamt, shiftsel,
        input  busy, done, result, result_hi, zero, negative, div_by_zero
    );

    modport slave (
        input  start, op, a, b, shamt, shiftsel,
        output busy, done, result, result_hi, zero, negative, div_by_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential MIPS ALU: registered single-cycle ops plus iterative multiply and
// restoring divide returning a HI/LO pair through a start/busy/done handshake.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    alu_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpOr    = 4'b0010;
    localparam logic [3:0] OpSltu  = 4'b0011;
    localparam logic [3:0] OpAnd   = 4'b0100;
    localparam logic [3:0] OpXor   = 4'b0101;
    localparam logic [3:0] OpNor   = 4'b0110;
    localparam logic [3:0] OpSll   = 4'b0111;
    localparam logic [3:0] OpSrl   = 4'b1000;
    localparam logic [3:0] OpSra   = 4'b1001;
    localparam logic [3:0] OpPassA = 4'b1010;
    localparam logic [3:0] OpPassB = 4'b1011;
    localparam logic [3:0] OpSlt   = 4'b1100;
    localparam logic [3:0] OpMultu = 4'b1101;
    localparam logic [3:0] OpMult  = 4'b1110;
    localparam logic [3:0] OpDivu  = 4'b1111;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic             sign_q;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             zero_q, negative_q, dbz_q, done_q;

    logic             is_iter, busy, accept_single, accept_iter, finish;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res, a_mag, b_load;
    logic             signed_mul, sign_load;
    logic [WIDTH:0]   mul_sum, div_diff;
    logic [2*WIDTH-1:0] prod_step, prod_fin;
    logic             load_res, dbz_d;
    logic [WIDTH-1:0] res_d, res_hi_d;

    assign is_iter = (bus.op >= OpMultu);

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start && is_iter) state_d = StRun;
            StRun:   if (cnt_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q == StRun);
        accept_single = (state_q == StIdle) && bus.start && !is_iter;
        accept_iter   = (state_q == StIdle) && bus.start && is_iter;
        finish        = (state_q == StRun) && (cnt_q == '0);
    end

    always_comb begin
        sh      = bus.shiftsel ? bus.a[SHW-1:0] : bus.shamt;
        alu_res = '0;
        case (bus.op)
            OpAdd:   alu_res = bus.a + bus.b;
            OpSub:   alu_res = bus.a - bus.b;
            OpOr:    alu_res = bus.a | bus.b;
            OpSltu:  alu_res = WIDTH'(bus.a < bus.b);
            OpAnd:   alu_res = bus.a & bus.b;
            OpXor:   alu_res = bus.a ^ bus.b;
            OpNor:   alu_res = ~(bus.a | bus.b);
            OpSll:   alu_res = bus.b << sh;
            OpSrl:   alu_res = bus.b >> sh;
            OpSra:   alu_res = $signed(bus.b) >>> sh;
            OpPassA: alu_res = bus.a;
            OpPassB: alu_res = bus.b;
            OpSlt:   alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            default: alu_res = '0;
        endcase
    end

    // Signed multiply runs on magnitudes; -2^(WIDTH-1) maps to itself as unsigned.
    always_comb begin
        signed_mul = (bus.op == OpMult);
        a_mag      = (signed_mul && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_load     = (signed_mul && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        sign_load  = signed_mul && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end

    // prod_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
        div_diff = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        if (op_q == OpDivu) begin
            prod_step = div_diff[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
            prod_step = {mul_sum, prod_q[WIDTH-1:1]};
        end
        prod_fin = sign_q ? -prod_step : prod_step;
    end

    always_comb begin
        load_res = accept_single || finish;
        res_d    = alu_res;
        res_hi_d = '0;
        dbz_d    = 1'b0;
        if (finish) begin
            if (op_q == OpDivu) begin
                res_d    = prod_step[WIDTH-1:0];
                res_hi_d = prod_step[2*WIDTH-1:WIDTH];
                dbz_d    = (b_q == '0);
            end else begin
                res_d    = prod_fin[WIDTH-1:0];
                res_hi_d = prod_fin[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            op_q        <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= load_res;
            if (accept_iter) begin
                op_q   <= bus.op;
                b_q    <= b_load;
                prod_q <= {{WIDTH{1'b0}}, a_mag};
                sign_q <= sign_load;
                cnt_q  <= SHW'(WIDTH - 1);
            end else if (busy) begin
                prod_q <= prod_step;
                if (cnt_q != '0) cnt_q <= cnt_q - SHW'(1);
            end
            if (load_res) begin
                result_q    <= res_d;
                result_hi_q <= res_hi_d;
                zero_q      <= (res_d == '0);
                negative_q  <= res_d[WIDTH-1];
                dbz_q       <= dbz_d;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.zero        = zero_q;
    assign bus.negative    = negative_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: table of single-cycle vectors plus
// hand-written multiply/divide, ignore-while-busy, reset-abort and back-to-back sequences.
module tb_alu_seq;
    localparam int unsigned W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic        shiftsel;
        logic [31:0] exp;
        logic        exp_z;
        logic        exp_n;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] flags();
        return {bus.done, bus.busy, bus.zero, bus.negative, bus.div_by_zero};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] shamt, input logic shiftsel);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = shamt;
        bus.shiftsel = shiftsel;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Leaves the bench in the done cycle (t+W+1) of the iterative op.
    task automatic run_iter(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int inject, input logic [31:0] exp_lo,
                            input logic [31:0] exp_hi, input logic [4:0] exp_flags);
        int bad;
        bad = 0;
        issue(op, a, b, 5'd0, 1'b0);
        for (int k = 1; k <= int'(W); k++) begin
            if (!(bus.busy === 1'b1 && bus.done === 1'b0)) bad++;
            if (k == inject) begin
                bus.op    = 4'b0000;
                bus.a     = 32'h1;
                bus.b     = 32'h1;
                bus.start = 1'b1;
            end
            if (k == inject + 1) bus.start = 1'b0;
            step();
        end
        check({name, " busy window"}, 64'(bad), 64'd0);
        check({name, " flags"}, 64'(flags()), 64'(exp_flags));
        check({name, " result"}, 64'(bus.result), 64'(exp_lo));
        check({name, " result_hi"}, 64'(bus.result_hi), 64'(exp_hi));
    endtask

    initial begin
        int seen_done;
        checks   = 0;
        failures = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.shamt    = '0;
        bus.shiftsel = 1'b0;

        vecs[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{4'h1, 32'h00000005, 32'h00000007, 5'd0,  1'b0, 32'hFFFFFFFE, 1'b0, 1'b1};
        vecs[2]  = '{4'h2, 32'h0000F0F0, 32'h00000F0F, 5'd0,  1'b0, 32'h0000FFFF, 1'b0, 1'b0};
        vecs[3]  = '{4'h3, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{4'h4, 32'hFF00FF00, 32'h0FF00FF0, 5'd0,  1'b0, 32'h0F000F00, 1'b0, 1'b0};
        vecs[5]  = '{4'h5, 32'hAAAA5555, 32'hFFFF0000, 5'd0,  1'b0, 32'h55555555, 1'b0, 1'b0};
        vecs[6]  = '{4'h6, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[7]  = '{4'h7, 32'h00000000, 32'h00000001, 5'd31, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[8]  = '{4'h8, 32'h00000000, 32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[9]  = '{4'h9, 32'h00000000, 32'h80000000, 5'd4,  1'b0, 32'hF8000000, 1'b0, 1'b1};
        vecs[10] = '{4'h9, 32'h00000024, 32'h80000000, 5'd0,  1'b1, 32'hF8000000, 1'b0, 1'b1};
        vecs[11] = '{4'h8, 32'h00000021, 32'h00000008, 5'd7,  1'b1, 32'h00000004, 1'b0, 1'b0};
        vecs[12] = '{4'hA, 32'h12345678, 32'h00000000, 5'd0,  1'b0, 32'h12345678, 1'b0, 1'b0};
        vecs[13] = '{4'hB, 32'h00000001, 32'h00000000, 5'd0,  1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{4'hC, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[15] = '{4'h7, 32'h00000000, 32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[16] = '{4'h1, 32'h00000005, 32'h00000005, 5'd0,  1'b0, 32'h00000000, 1'b1, 1'b0};

        step();
        step();
        rst = 1'b0;
        check("reset flags", 64'(flags()), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset result_hi", 64'(bus.result_hi), 64'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shamt, vecs[i].shiftsel);
            check($sformatf("vec%0d result", i), 64'(bus.result), 64'(vecs[i].exp));
            check($sformatf("vec%0d result_hi", i), 64'(bus.result_hi), 64'd0);
            check($sformatf("vec%0d flags", i), 64'(flags()),
                  64'({1'b1, 1'b0, vecs[i].exp_z, vecs[i].exp_n, 1'b0}));
        end
        step();
        check("single done pulse", 64'(flags()), 64'(5'b00100));
        check("single hold", 64'(bus.result), 64'd0);

        // mult -3 * 7 with a stray add request at edge t+5
        run_iter("mult", 4'hE, 32'hFFFFFFFD, 32'h7, 4, 32'hFFFFFFEB, 32'hFFFFFFFF, 5'b10010);
        step();
        check("mult hold flags", 64'(flags()), 64'(5'b00010));
        check("mult hold result", 64'({bus.result_hi, bus.result}), 64'hFFFFFFFF_FFFFFFEB);

        run_iter("multu max", 4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001, 32'hFFFFFFFE,
                 5'b10000);
        run_iter("mult minneg sq", 4'hE, 32'h80000000, 32'h80000000, 0, 32'h00000000,
                 32'h40000000, 5'b10100);
        run_iter("mult minneg x1", 4'hE, 32'h80000000, 32'h00000001, 0, 32'h80000000,
                 32'hFFFFFFFF, 5'b10010);

        run_iter("divu 100/7", 4'hF, 32'd100, 32'd7, 0, 32'd14, 32'd2, 5'b10000);
        run_iter("divu by0", 4'hF, 32'h1234, 32'h0, 0, 32'hFFFFFFFF, 32'h1234, 5'b10011);

        // divu 9/2 then a sub accepted in its done cycle
        run_iter("divu 9/2", 4'hF, 32'd9, 32'd2, 0, 32'd4, 32'd1, 5'b10000);
        issue(4'h1, 32'd5, 32'd5, 5'd0, 1'b0);
        check("b2b sub flags", 64'(flags()), 64'(5'b10100));
        check("b2b sub result", 64'({bus.result_hi, bus.result}), 64'd0);

        // multu aborted by reset at cycle t+10
        issue(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0);
        for (int k = 1; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort flags", 64'(flags()), 64'd0);
        check("abort result", 64'({bus.result_hi, bus.result}), 64'd0);
        seen_done = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
            step();
        end
        check("abort no done", 64'(seen_done), 64'd0);
        issue(4'h0, 32'd2, 32'd3, 5'd0, 1'b0);
        check("post-abort add", 64'(bus.result), 64'd5);
        check("post-abort flags", 64'(flags()), 64'(5'b10000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
